// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and dual-issue decode. It holds {pc_plus_4, instr}
// pairs in strict FIFO order and shows the two oldest entries to decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc4,
  input  logic [31:0]      enq_instr,
  output logic             enq_ready,
  output logic             deq0_valid,
  output logic [31:0]      deq0_pc4,
  output logic [31:0]      deq0_instr,
  output logic             deq1_valid,
  output logic [31:0]      deq1_pc4,
  output logic [31:0]      deq1_instr,
  input  logic [1:0]       deq_num,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_accept;
  logic [PTR_W:0]   w_req;
  logic [PTR_W:0]   w_eff;
  logic [PTR_W-1:0] w_head1;

  // Handshake: a pair moves on a rising edge only when enq_valid and enq_ready are both
  // high; enq_ready depends on stored state only, so a full queue refuses even while
  // decode is popping. Decode pops by asserting deq_num; it is clamped to what is valid.
  assign w_accept = enq_valid && (r_count < L_FULL);

  always_comb begin
    w_req = '0;
    case (deq_num)
      2'd0:    w_req = (PTR_W+1)'(0);
      2'd1:    w_req = (PTR_W+1)'(1);
      default: w_req = (PTR_W+1)'(2);
    endcase
    w_eff = (w_req > r_count) ? r_count : w_req;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_tail] <= {enq_pc4, enq_instr};
        r_tail        <= r_tail + PTR_W'(1);
      end
      // Modulo-DEPTH advance is free because DEPTH is a power of two.
      r_head  <= r_head + w_eff[PTR_W-1:0];
      r_count <= r_count + (PTR_W+1)'(w_accept) - w_eff;
    end
  end

  assign w_head1    = r_head + PTR_W'(1);
  assign count      = r_count;
  assign enq_ready  = (r_count < L_FULL);
  assign deq0_valid = (r_count >= (PTR_W+1)'(1));
  assign deq1_valid = (r_count >= (PTR_W+1)'(2));
  assign deq0_pc4   = deq0_valid ? r_mem[r_head][63:32]  : 32'h0;
  assign deq0_instr = deq0_valid ? r_mem[r_head][31:0]   : 32'h0;
  assign deq1_pc4   = deq1_valid ? r_mem[w_head1][63:32] : 32'h0;
  assign deq1_instr = deq1_valid ? r_mem[w_head1][31:0]  : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of single-cycle vectors plus hand-written
// sequences for reset, wrap-around and flush.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic [31:0] enq_pc4;
  logic [31:0] enq_instr;
  logic        enq_ready;
  logic        deq0_valid;
  logic [31:0] deq0_pc4;
  logic [31:0] deq0_instr;
  logic        deq1_valid;
  logic [31:0] deq1_pc4;
  logic [31:0] deq1_instr;
  logic [1:0]  deq_num;
  logic [2:0]  count;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        flush;
    logic        ev;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [1:0]  dn;
    logic [2:0]  cnt;
    logic        rdy;
    logic        d0v;
    logic [31:0] d0p;
    logic [31:0] d0i;
    logic        d1v;
    logic [31:0] d1p;
    logic [31:0] d1i;
  } vec_t;

  vec_t vecs[$];

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_pc4(enq_pc4), .enq_instr(enq_instr), .enq_ready(enq_ready),
    .deq0_valid(deq0_valid), .deq0_pc4(deq0_pc4), .deq0_instr(deq0_instr),
    .deq1_valid(deq1_valid), .deq1_pc4(deq1_pc4), .deq1_instr(deq1_instr),
    .deq_num(deq_num), .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] cnt, input logic rdy,
                           input logic d0v, input logic [31:0] d0p, input logic [31:0] d0i,
                           input logic d1v, input logic [31:0] d1p, input logic [31:0] d1i);
    check({tag, ".count"}, 32'(count), 32'(cnt));
    check({tag, ".enq_ready"}, 32'(enq_ready), 32'(rdy));
    check({tag, ".deq0_valid"}, 32'(deq0_valid), 32'(d0v));
    check({tag, ".deq0_pc4"}, deq0_pc4, d0p);
    check({tag, ".deq0_instr"}, deq0_instr, d0i);
    check({tag, ".deq1_valid"}, 32'(deq1_valid), 32'(d1v));
    check({tag, ".deq1_pc4"}, deq1_pc4, d1p);
    check({tag, ".deq1_instr"}, deq1_instr, d1i);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic drive(input logic fl, input logic ev, input logic [31:0] pc4,
                       input logic [31:0] instr, input logic [1:0] dn);
    @(negedge clk);
    reset     = 1'b0;
    flush     = fl;
    enq_valid = ev;
    enq_pc4   = pc4;
    enq_instr = instr;
    deq_num   = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b1;
    enq_pc4   = 32'hdead_0004;
    enq_instr = 32'hdead_beef;
    deq_num   = 2'd0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0;
    enq_pc4 = '0; enq_instr = '0; deq_num = '0;

    // reset held two cycles with a push offered
    do_reset(2);
    check_all("reset", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // table: {flush, ev, pc4, instr, dn} -> state after the edge
    vecs.push_back('{1'b0, 1'b1, 32'h04, 32'h20080005, 2'd0, 3'd1, 1'b1, 1'b1, 32'h04, 32'h20080005, 1'b0, 32'h0,  32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h08, 32'h20090007, 2'd0, 3'd2, 1'b1, 1'b1, 32'h04, 32'h20080005, 1'b1, 32'h08, 32'h20090007});
    vecs.push_back('{1'b0, 1'b1, 32'h0C, 32'h200A0001, 2'd0, 3'd3, 1'b1, 1'b1, 32'h04, 32'h20080005, 1'b1, 32'h08, 32'h20090007});
    vecs.push_back('{1'b0, 1'b1, 32'h10, 32'h200B0002, 2'd0, 3'd4, 1'b0, 1'b1, 32'h04, 32'h20080005, 1'b1, 32'h08, 32'h20090007});
    // full: push refused while two pop
    vecs.push_back('{1'b0, 1'b1, 32'h14, 32'h200C0003, 2'd2, 3'd2, 1'b1, 1'b1, 32'h0C, 32'h200A0001, 1'b1, 32'h10, 32'h200B0002});
    vecs.push_back('{1'b0, 1'b0, 32'h00, 32'h00000000, 2'd1, 3'd1, 1'b1, 1'b1, 32'h10, 32'h200B0002, 1'b0, 32'h0,  32'h0});
    // count=1, pop 2 plus push: clamp to 1, new entry becomes oldest
    vecs.push_back('{1'b0, 1'b1, 32'h18, 32'h200D0004, 2'd2, 3'd1, 1'b1, 1'b1, 32'h18, 32'h200D0004, 1'b0, 32'h0,  32'h0});
    // deq_num=3 acts as 2, clamped to 1
    vecs.push_back('{1'b0, 1'b0, 32'h00, 32'h00000000, 2'd3, 3'd0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,  32'h0});
    // pop on empty must not underflow
    vecs.push_back('{1'b0, 1'b1, 32'h1C, 32'h200E0005, 2'd2, 3'd1, 1'b1, 1'b1, 32'h1C, 32'h200E0005, 1'b0, 32'h0,  32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h20, 32'h200F0006, 2'd0, 3'd2, 1'b1, 1'b1, 32'h1C, 32'h200E0005, 1'b1, 32'h20, 32'h200F0006});
    vecs.push_back('{1'b0, 1'b1, 32'h24, 32'h20100007, 2'd1, 3'd2, 1'b1, 1'b1, 32'h20, 32'h200F0006, 1'b1, 32'h24, 32'h20100007});
    vecs.push_back('{1'b0, 1'b0, 32'h00, 32'h00000000, 2'd2, 3'd0, 1'b1, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,  32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].ev, vecs[i].pc4, vecs[i].instr, vecs[i].dn);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdy, vecs[i].d0v,
                vecs[i].d0p, vecs[i].d0i, vecs[i].d1v, vecs[i].d1p, vecs[i].d1i);
    end

    // wrap-around: one push and one pop per cycle, scoreboard tracks FIFO order
    exp_q.delete();
    drive(1'b0, 1'b1, 32'h04, 32'h1000_0004, 2'd0);
    exp_q.push_back(32'h04);
    check("wrap.count0", 32'(count), 32'd1);
    check("wrap.pc4_0", deq0_pc4, exp_q[0]);
    for (int k = 2; k <= 10; k++) begin
      drive(1'b0, 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(4 * k), 2'd1);
      exp_q.push_back(32'(4 * k));
      void'(exp_q.pop_front());
      check($sformatf("wrap.count%0d", k), 32'(count), 32'd1);
      check($sformatf("wrap.pc4_%0d", k), deq0_pc4, exp_q[0]);
      check($sformatf("wrap.instr_%0d", k), deq0_instr, 32'h1000_0000 + exp_q[0]);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd1);
    void'(exp_q.pop_front());
    check("wrap.drained", 32'(count), 32'd0);
    check("wrap.queue_empty", 32'(exp_q.size()), 32'd0);

    // flush with a same-cycle push and pop: everything discarded
    drive(1'b0, 1'b1, 32'h100, 32'hAAAA_0001, 2'd0);
    drive(1'b0, 1'b1, 32'h104, 32'hAAAA_0002, 2'd0);
    drive(1'b0, 1'b1, 32'h108, 32'hAAAA_0003, 2'd0);
    check("flush.pre_count", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 32'h10C, 32'hAAAA_0004, 2'd1);
    check_all("flush", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'h200, 32'hBBBB_0001, 2'd0);
    check_all("post_flush", 3'd1, 1'b1, 1'b1, 32'h200, 32'hBBBB_0001, 1'b0, 32'h0, 32'h0);

    // reset mid-operation overrides pending entries and the offered push
    drive(1'b0, 1'b1, 32'h204, 32'hBBBB_0002, 2'd0);
    do_reset(1);
    check_all("mid_reset", 3'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'h300, 32'hCCCC_0001, 2'd0);
    check_all("after_reset", 3'd1, 1'b1, 1'b1, 32'h300, 32'hCCCC_0001, 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
